branch_predictor: RTL
=====================

# branch_predictor

Parametrised branch unit for the RV32I pipeline. It combines two jobs. In EX it resolves branches, JAL and JALR from comparator flags. In IF it predicts the next PC from a direct-mapped branch target buffer (BTB) holding 2-bit saturating counters. It drives the front-end redirect on misprediction and is trained each cycle by the instruction in EX.

## Interface
Parameters:
- XLEN, 32: address width.
- ENTRIES, 64: BTB depth. Must be a power of two, at least 4. IDX_W = log2(ENTRIES), TAG_W = XLEN-IDX_W-2.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, synchronous and active-low.
- pc_IF  in  XLEN  fetch PC.
- pred_taken_IF  out  1  prediction for pc_IF: taken.
- pred_target_IF  out  XLEN  predicted next PC.
- ex_valid  in  1  EX holds a live, unflushed instruction.
- opcode_EX  in  rv32_pkg::opcode_t  EX opcode.
- funct3_EX  in  rv32_pkg::funct3_t  EX funct3.
- pc_EX  in  XLEN  PC of the EX instruction.
- target_EX  in  XLEN  computed branch/jump target. JALR LSB is already cleared.
- BrEq, BrLT  in  1  comparator flags. BrLT is signed or unsigned according to funct3.
- pred_taken_EX, pred_target_EX  in  1/XLEN  prediction made in IF, carried down the pipe.
- PCSel  out  1  actual taken.
- mispredict  out  1  front-end redirect request.
- redirect_pc  out  XLEN  correct next PC.
- br_cnt, mispred_cnt  out  32  performance counters (see Configuration).

## Operation
- Control-flow instruction (cf): ex_valid and opcode in {OC_B, OC_J, OC_I_JALR}.
- Resolution (combinational, PCSel forced 0 unless cf):
  - BEQ: BrEq.
  - BNE: ~BrEq.
  - BLT, BLTU: BrLT.
  - BGE, BGEU: ~BrLT|BrEq.
  - JAL, JALR: 1.
  - Undefined OC_B funct3: 0.
- mispredict = cf & ((PCSel != pred_taken_EX) | (PCSel & pred_target_EX != target_EX)).
- redirect_pc = PCSel ? target_EX : pc_EX+4. redirect_pc is meaningful only while mispredict=1.
- BTB entry fields: valid, tag, target, ctr[1:0].
  - index = pc[IDX_W+1:2].
  - tag = pc[XLEN-1:IDX_W+2].
- Prediction: hit = valid & tag match on pc_IF.
  - pred_taken_IF = hit & ctr[1].
  - pred_target_IF = pred_taken_IF ? target : pc_IF+4.
- Update at posedge, only when cf. Indexed by pc_EX.
  - Hit, OC_B: ctr saturates up if taken, down if not taken (00 floor, 11 ceiling). target is rewritten when taken.
  - Hit, JAL/JALR: ctr := 11, target := target_EX.
  - Miss and taken: allocate, overwriting the entry. valid := 1, tag, target := target_EX. ctr := 10 for OC_B, 11 for jumps.
  - Miss and not taken: no write.
- Non-cf or ex_valid=0: no BTB write, counters unchanged.

## Timing
- Prediction: zero-latency combinational read of pc_IF.
- Resolution: combinational within the EX cycle.
- Training: visible to pc_IF from the cycle after the update edge.
- Same-cycle read and write of the same index: the read returns the pre-update entry. There is no bypass.
- Reset (rst_n low at posedge):
  - All valid := 0 and all ctr := 01.
  - Perf counters := 0.
  - Next cycle: pred_taken_IF=0 and pred_target_IF=pc_IF+4 for every PC.
  - PCSel and mispredict remain combinational. The pipeline holds ex_valid=0 during reset.
- Reset mid-training: the reset wins over a coincident update.
- Aliasing: a PC that maps to an occupied index with a different tag is a miss.

## Configuration
Macro: BP_PERF_CNT_EN.
- Defined:
  - br_cnt increments on every cf cycle.
  - mispred_cnt increments on every mispredict cycle.
  - Both counters wrap modulo 2^32.
- Undefined: no counter flops; br_cnt and mispred_cnt are tied to 0.

## Structure
- rv32_pkg already holds opcode_t, funct3_t, the OC_* opcodes and the F3_* codes.
- Add to rv32_pkg:
  - bp_ctr_t (2-bit) with constants SNT=00, WNT=01, WT=10, ST=11.
  - bp_entry_t struct with fields valid, tag, target, ctr.
- Sub-module bp_resolve: combinational. Takes opcode, funct3, BrEq and BrLT; outputs PCSel and a cf flag. branch_predictor instantiates it and holds the BTB array, the update logic and the counters.

## Test plan
- Reset, then pc_IF=0x100 -> pred_taken_IF=0, pred_target_IF=0x104. With the macro, br_cnt=0.
- BEQ taken at pc_EX=0x100, target 0x180, pred_taken_EX=0 -> PCSel=1, mispredict=1, redirect_pc=0x180. Next cycle, pc_IF=0x100 -> pred_taken_IF=1, target 0x180 (ctr=WT).
- The same BEQ twice not taken, each with pred_taken_EX matching the prediction of that cycle. First: ctr 10->01, mispredict=1, redirect_pc=0x104. Second: ctr 01->00, mispredict=0. Then pc_IF=0x100 -> pred_taken_IF=0.
- Correct prediction: JALR at 0x200 allocated with target 0x300. Re-executed with target_EX=0x300 and pred_target_EX=0x300 -> mispredict=0.
- Aliasing with ENTRIES=64: 0x100 and 0x200 share index 0. Taken branch at 0x200 evicts 0x100 -> pc_IF=0x100 then predicts not taken.
- Boundary cases:
  - BGE with BrEq=1, BrLT=1 -> PCSel=1.
  - ex_valid=0 with opcode OC_J -> PCSel=0, no BTB write.
  - Counter wrap: mispred_cnt preset to 0xFFFFFFFF by force, then one mispredict -> 0.

Source files
------------

// File: rtl/rv32_pkg.sv
// RV32I shared types: opcodes, funct3 codes and branch-predictor BTB types.
package rv32_pkg;

   typedef enum logic [6:0] {
      OC_I_LOAD  = 7'b0000011,
      OC_I_FENCE = 7'b0001111,
      OC_I       = 7'b0010011,
      OC_AUIPC   = 7'b0010111,
      OC_S       = 7'b0100011,
      OC_R       = 7'b0110011,
      OC_LUI     = 7'b0110111,
      OC_B       = 7'b1100011,
      OC_I_JALR  = 7'b1100111,
      OC_J       = 7'b1101111,
      OC_I_SYS   = 7'b1110011
   } opcode_t;

   // funct3 values overlap across instruction classes, so plain codes rather than an enum
   typedef logic [2:0] funct3_t;

   localparam funct3_t F3_BEQ  = 3'b000;
   localparam funct3_t F3_BNE  = 3'b001;
   localparam funct3_t F3_BLT  = 3'b100;
   localparam funct3_t F3_BGE  = 3'b101;
   localparam funct3_t F3_BLTU = 3'b110;
   localparam funct3_t F3_BGEU = 3'b111;

   // Storage width of BTB tag/target fields; the predictor zero-extends into these
   localparam int unsigned BP_XLEN = 32;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bp_ctr_t;

   typedef struct packed {
      logic                valid;
      logic [BP_XLEN-1:0]  tag;
      logic [BP_XLEN-1:0]  target;
      bp_ctr_t             ctr;
   } bp_entry_t;

   // 2-bit saturating counter step: up on taken, down on not taken
   function automatic bp_ctr_t bp_ctr_next(input bp_ctr_t c, input logic taken);
      bp_ctr_t n;
      case (c)
         SNT:     n = taken ? WNT : SNT;
         WNT:     n = taken ? WT  : SNT;
         WT:      n = taken ? ST  : WNT;
         default: n = taken ? ST  : WT;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/bp_resolve.sv
// Branch/jump resolution from comparator flags; purely combinational.
module bp_resolve
   import rv32_pkg::*;
(
   input  logic    valid,
   input  opcode_t opcode,
   input  funct3_t funct3,
   input  logic    br_eq,
   input  logic    br_lt,
   output logic    pc_sel,
   output logic    cf
);

   // Classify control flow and decide taken; not-taken unless a live cf instruction
   always_comb begin
      cf     = valid && (opcode == OC_B || opcode == OC_J || opcode == OC_I_JALR);
      pc_sel = 1'b0;
      if (cf) begin
         case (opcode)
            OC_B: begin
               case (funct3)
                  F3_BEQ:          pc_sel = br_eq;
                  F3_BNE:          pc_sel = ~br_eq;
                  F3_BLT, F3_BLTU: pc_sel = br_lt;
                  F3_BGE, F3_BGEU: pc_sel = ~br_lt | br_eq;
                  default:         pc_sel = 1'b0;
               endcase
            end
            OC_J, OC_I_JALR: pc_sel = 1'b1;
            default:         pc_sel = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Branch unit: EX resolution/redirect plus direct-mapped BTB prediction in IF.
// Optional performance counters enabled by defining BP_PERF_CNT_EN.
module branch_predictor
   import rv32_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned ENTRIES = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] pc_IF,
   output logic            pred_taken_IF,
   output logic [XLEN-1:0] pred_target_IF,
   input  logic            ex_valid,
   input  opcode_t         opcode_EX,
   input  funct3_t         funct3_EX,
   input  logic [XLEN-1:0] pc_EX,
   input  logic [XLEN-1:0] target_EX,
   input  logic            BrEq,
   input  logic            BrLT,
   input  logic            pred_taken_EX,
   input  logic [XLEN-1:0] pred_target_EX,
   output logic            PCSel,
   output logic            mispredict,
   output logic [XLEN-1:0] redirect_pc,
   output logic [31:0]     br_cnt,
   output logic [31:0]     mispred_cnt
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_W = XLEN - IDX_W - 2;

   bp_entry_t btb [ENTRIES];

   logic [IDX_W-1:0]   idx_if, idx_ex;
   logic [BP_XLEN-1:0] tag_if, tag_ex;
   bp_entry_t          rd_if, rd_ex, wr_entry;
   logic               hit_ex, cf, wr_en;

   bp_resolve u_resolve (
      .valid  (ex_valid),
      .opcode (opcode_EX),
      .funct3 (funct3_EX),
      .br_eq  (BrEq),
      .br_lt  (BrLT),
      .pc_sel (PCSel),
      .cf     (cf)
   );

   assign idx_if = pc_IF[IDX_W+1:2];
   assign idx_ex = pc_EX[IDX_W+1:2];
   assign tag_if = BP_XLEN'(pc_IF[IDX_W+2 +: TAG_W]);
   assign tag_ex = BP_XLEN'(pc_EX[IDX_W+2 +: TAG_W]);
   assign rd_if  = btb[idx_if];
   assign rd_ex  = btb[idx_ex];
   assign hit_ex = rd_ex.valid && (rd_ex.tag == tag_ex);

   // IF prediction: pre-update array contents, no write bypass
   always_comb begin
      pred_taken_IF  = rd_if.valid && (rd_if.tag == tag_if) && rd_if.ctr[1];
      pred_target_IF = pred_taken_IF ? rd_if.target[XLEN-1:0] : pc_IF + XLEN'(4);
   end

   // EX redirect decision
   always_comb begin
      mispredict  = cf && ((PCSel != pred_taken_EX) ||
                           (PCSel && (pred_target_EX != target_EX)));
      redirect_pc = PCSel ? target_EX : pc_EX + XLEN'(4);
   end

   // Training: build the replacement entry for the EX index
   always_comb begin
      wr_en    = 1'b0;
      wr_entry = rd_ex;
      if (cf) begin
         if (hit_ex) begin
            wr_en = 1'b1;
            if (opcode_EX == OC_B) begin
               wr_entry.ctr = bp_ctr_next(rd_ex.ctr, PCSel);
               if (PCSel) wr_entry.target = BP_XLEN'(target_EX);
            end else begin
               wr_entry.ctr    = ST;
               wr_entry.target = BP_XLEN'(target_EX);
            end
         end else if (PCSel) begin
            wr_en           = 1'b1;
            wr_entry.valid  = 1'b1;
            wr_entry.tag    = tag_ex;
            wr_entry.target = BP_XLEN'(target_EX);
            wr_entry.ctr    = (opcode_EX == OC_B) ? WT : ST;
         end
      end
   end

   // BTB storage; reset clears valid and parks counters weakly not-taken
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            btb[i].valid <= 1'b0;
            btb[i].ctr   <= WNT;
         end
      end else if (wr_en) begin
         btb[idx_ex] <= wr_entry;
      end
   end

`ifdef BP_PERF_CNT_EN
   logic [31:0] br_q, mispred_q;

   // Performance counters, free-running with natural 32-bit wrap
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         br_q      <= '0;
         mispred_q <= '0;
      end else begin
         if (cf)         br_q      <= br_q + 32'd1;
         if (mispredict) mispred_q <= mispred_q + 32'd1;
      end
   end

   assign br_cnt      = br_q;
   assign mispred_cnt = mispred_q;
`else
   assign br_cnt      = '0;
   assign mispred_cnt = '0;
`endif

endmodule
